// File: rtl/convolution_stage2.sv
`default_nettype none
// ============================================================================
// Module   : convolution_stage2
// Brief    : Sums one kernel window of signed tap products plus bias, then
//            applies optional ReLU and 8-bit saturation into a valid/ready
//            output register.
// Revision : 1.0 - initial release
// ============================================================================
module convolution_stage2 #(
    parameter int TAPS  = 9,
    parameter int ACC_W = 12,
    parameter bit RELU  = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       prod,
    input  logic             prod_valid,
    output logic             prod_ready,
    input  logic [7:0]       bias,
    input  logic             clear,
    output logic [ACC_W-1:0] out_sum,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       tap_count,
    output logic             busy
);

    localparam logic [3:0]              c_LAST_TAP = 4'(TAPS - 1);
    localparam logic signed [ACC_W-1:0] c_SAT_MAX  = ACC_W'(127);
    localparam logic signed [ACC_W-1:0] c_SAT_MIN  = -ACC_W'(128);

    logic signed [ACC_W-1:0] r_acc;
    logic signed [ACC_W-1:0] r_out_sum;
    logic [7:0]              r_out_data;
    logic                    r_out_valid;
    logic [3:0]              r_tap_count;

    logic                    w_last;
    logic                    w_prod_ready;
    logic                    w_accept;
    logic signed [ACC_W-1:0] w_base;
    logic signed [ACC_W-1:0] w_sum;
    logic signed [ACC_W-1:0] w_relu;
    logic [7:0]              w_sat;

    assign w_last       = (r_tap_count == c_LAST_TAP);
    // Only the final tap can stall: it would overwrite an unconsumed result.
    assign w_prod_ready = !rst && !clear && !(w_last && r_out_valid && !out_ready);
    assign w_accept     = prod_valid && w_prod_ready;

    // The first tap of a window starts from the bias instead of the accumulator.
    assign w_base = (r_tap_count == 4'd0) ? {{(ACC_W-8){bias[7]}}, bias} : r_acc;
    assign w_sum  = w_base + {{(ACC_W-8){prod[7]}}, prod};
    assign w_relu = (RELU && w_sum[ACC_W-1]) ? '0 : w_sum;

    always_comb begin
        w_sat = w_relu[7:0];
        if (w_relu > c_SAT_MAX) begin
            w_sat = 8'h7F;
        end else if (w_relu < c_SAT_MIN) begin
            w_sat = 8'h80;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc       <= '0;
            r_out_sum   <= '0;
            r_out_data  <= 8'h00;
            r_out_valid <= 1'b0;
            r_tap_count <= 4'd0;
        end else begin
            if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (clear) begin
                r_acc       <= '0;
                r_tap_count <= 4'd0;
            end else if (w_accept) begin
                if (w_last) begin
                    r_out_sum   <= w_sum;
                    r_out_data  <= w_sat;
                    r_out_valid <= 1'b1;
                    r_acc       <= '0;
                    r_tap_count <= 4'd0;
                end else begin
                    r_acc       <= w_sum;
                    r_tap_count <= r_tap_count + 4'd1;
                end
            end
        end
    end

    assign prod_ready = w_prod_ready;
    assign out_sum    = r_out_sum;
    assign out_data   = r_out_data;
    assign out_valid  = r_out_valid;
    assign tap_count  = r_tap_count;
    assign busy       = (r_tap_count != 4'd0);

endmodule
`default_nettype wire
